alu_seq_stage: RTL and testbench
================================

ALU_SEQ_STAGE -- requirements
Module: alu_seq_stage

Interface
REQ-001 SHALL use a single clock; reset is synchronous and active-high.
REQ-002 SHALL have port clk, input, 1: rising-edge clock for all state.
REQ-003 SHALL have port clr, input, 1: synchronous active-high reset.
REQ-004 SHALL have port bus_in, input, 32: shared datapath bus; Y load data, or operand Rb/shift count at start.
REQ-005 SHALL have port y_in, input, 1: load bus_in into the Y register (operand Ra) at the clock edge.
REQ-006 SHALL have port start, input, 1: issue an operation using Y as Ra and bus_in as Rb.
REQ-007 SHALL have port op, input, 4: operation code, sampled with start.
REQ-008 SHALL have port z_lo, output, 32: registered result, low word.
REQ-009 SHALL have port z_hi, output, 32: registered result, high word.
REQ-010 SHALL have port busy, output, 1: high while an iterative operation is in progress.
REQ-011 SHALL have port done, output, 1: one-cycle pulse when Z has been updated.

Function
REQ-012 SHALL implement states IDLE, BUSY and DONE; Z holds its value between operations.
REQ-013 SHALL decode op as: 0 AND, 1 OR, 2 XOR, 3 NOT (~Rb), 4 NEG (-Rb), 5 ADD, 6 SUB (Ra-Rb), 7 SHL, 8 SHR, 9 SHRA, A ROL, B ROR; C-F are illegal.
REQ-014 SHALL accept start only in IDLE or DONE; start while BUSY SHALL be ignored with no state change.
REQ-015 SHALL, for ops 0-6 and illegal ops, write Z on the accepting edge k; done SHALL be high for the cycle after edge k; busy SHALL stay low.
REQ-016 SHALL set z_hi[0] = carry-out for ADD and z_hi[0] = borrow (Ra<Rb unsigned) for SUB; z_hi[31:1] = 0 for ADD/SUB; z_hi = 0 for all other ops.
REQ-017 SHALL produce Z = 0 (z_hi and z_lo) for illegal ops, still pulsing done.
REQ-018 SHALL, for ops 7-B, shift or rotate Ra by n = Rb[4:0] (Rb[31:5] ignored), one bit position per cycle, in an internal working register.
REQ-019 SHALL, for a shift with n = 0, complete like REQ-015 with z_lo = Ra.
REQ-020 SHALL, for a shift with n > 0, enter BUSY at edge k with busy high for n cycles, write z_lo at edge k+n, and raise done for the cycle after edge k+n; Z SHALL NOT change during BUSY.
REQ-021 SHALL zero-fill for SHL and SHR, replicate bit 31 for SHRA, and wrap bits for ROL and ROR.
REQ-022 SHALL perform all arithmetic modulo 2^32 on z_lo; no overflow flag.
REQ-023 SHALL honour y_in in every state; when y_in and start are asserted in the same cycle, the operation SHALL use the old Y and Y SHALL take bus_in.
REQ-024 SHALL return from DONE to IDLE after one cycle, or accept a new start in DONE (back-to-back operation).
REQ-025 SHALL drive busy and done from registers only.

Reset
REQ-026 SHALL, on clr at a clock edge, force state to IDLE and clear Y, the working register, z_lo, z_hi, busy and done to 0, including mid-operation; clr SHALL take priority over start and y_in.

Verification
REQ-027 SHALL cover: Y=0xAAAAAAAA, start op=0 with bus=0x55555555 -> z_lo=0x00000000, done one cycle, busy never high.
REQ-028 SHALL cover: Y=0xFFFFFFFF, ADD with bus=0x00000001 -> z_lo=0x00000000, z_hi=0x00000001; Y=0x00000037, SUB with bus=0x00000073 -> z_lo=0xFFFFFFC4, z_hi=0x00000001.
REQ-029 SHALL cover: Y=0x80000001, SHRA with bus=4 -> busy 4 cycles, z_lo=0xF8000000 at edge k+4, done the next cycle; repeat with ROR -> z_lo=0x18000000.
REQ-030 SHALL cover: SHL with bus=0x00000020 (n=0) -> z_lo=Y after one cycle, no busy.
REQ-031 SHALL cover: start during BUSY is ignored; clr asserted at cycle 2 of ROL by 10 -> all outputs 0 and IDLE next cycle.
REQ-032 SHALL cover: illegal op 0xE -> Z=0 with a done pulse; same-cycle y_in and start -> the result uses the old Y.

Source files
------------

// File: rtl/alu_seq_stage.sv
// ---------------------------------------------------------------------------
// alu_seq_stage
//   Sequential ALU stage. The Y register holds operand Ra; operand Rb (or
//   the shift count) comes from the shared bus when an operation is started.
//   Logic and arithmetic ops finish on the accepting edge. Shifts and
//   rotates move a working register one bit per cycle.
//
// Ports
//   clk     : rising-edge clock for all state
//   clr     : synchronous active-high clear, overrides start and y_in
//   bus_in  : Y load data, or Rb / shift count when start is high
//   y_in    : load bus_in into Y at the clock edge (honoured in every state)
//   start   : issue op using Y as Ra and bus_in as Rb (ignored while busy)
//   op      : operation code, sampled with start
//   z_lo    : registered result, low word
//   z_hi    : registered result, high word (carry / borrow in bit 0)
//   busy    : high while an iterative shift/rotate is in progress
//   done    : one-cycle pulse after Z has been updated
// ---------------------------------------------------------------------------
module alu_seq_stage (
   input  logic        clk,
   input  logic        clr,
   input  logic [31:0] bus_in,
   input  logic        y_in,
   input  logic        start,
   input  logic [3:0]  op,
   output logic [31:0] z_lo,
   output logic [31:0] z_hi,
   output logic        busy,
   output logic        done
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_e;

   typedef enum logic [3:0] {
      OP_AND  = 4'h0,
      OP_OR   = 4'h1,
      OP_XOR  = 4'h2,
      OP_NOT  = 4'h3,
      OP_NEG  = 4'h4,
      OP_ADD  = 4'h5,
      OP_SUB  = 4'h6,
      OP_SHL  = 4'h7,
      OP_SHR  = 4'h8,
      OP_SHRA = 4'h9,
      OP_ROL  = 4'hA,
      OP_ROR  = 4'hB
   } op_e;

   state_e      state, state_d;
   logic [31:0] y, y_d;
   logic [31:0] work, work_d;
   logic [4:0]  cnt, cnt_d;
   logic [3:0]  sop, sop_d;          // shift op latched at start
   logic [31:0] z_lo_d, z_hi_d;
   logic        busy_d, done_d;

   logic [31:0] res_lo, res_hi;      // single-cycle result
   logic [32:0] sum;
   logic [31:0] work_step;
   logic        is_shift;

   assign sum      = {1'b0, y} + {1'b0, bus_in};
   assign is_shift = (op >= OP_SHL) && (op <= OP_ROR);

   // Single-cycle result. Shift ops only reach here with a zero count, in
   // which case the result is Ra unchanged. Illegal codes yield zero.
   always_comb begin
      // NOTE: every combinational output gets a default first, so no path
      // leaves it unassigned and no latch is inferred.
      res_lo = '0;
      res_hi = '0;
      case (op)
         OP_AND:  res_lo = y & bus_in;
         OP_OR:   res_lo = y | bus_in;
         OP_XOR:  res_lo = y ^ bus_in;
         OP_NOT:  res_lo = ~bus_in;
         OP_NEG:  res_lo = -bus_in;
         OP_ADD: begin
            res_lo = sum[31:0];
            res_hi = {31'b0, sum[32]};
         end
         OP_SUB: begin
            res_lo = y - bus_in;
            res_hi = {31'b0, (y < bus_in)};
         end
         OP_SHL, OP_SHR, OP_SHRA, OP_ROL, OP_ROR: res_lo = y;
         default: ;
      endcase
   end

   // One bit position of the latched shift/rotate.
   always_comb begin
      work_step = work;
      case (sop)
         OP_SHL:  work_step = {work[30:0], 1'b0};
         OP_SHR:  work_step = {1'b0, work[31:1]};
         OP_SHRA: work_step = {work[31], work[31:1]};
         OP_ROL:  work_step = {work[30:0], work[31]};
         OP_ROR:  work_step = {work[0], work[31:1]};
         default: ;
      endcase
   end

   // Next-state and registered-output logic. busy/done are computed here
   // and registered below, so the ports come straight from flops.
   always_comb begin
      state_d = state;
      y_d     = y_in ? bus_in : y;   // old Y feeds this cycle's operation
      work_d  = work;
      cnt_d   = cnt;
      sop_d   = sop;
      z_lo_d  = z_lo;
      z_hi_d  = z_hi;
      busy_d  = 1'b0;
      done_d  = 1'b0;

      case (state)
         S_IDLE, S_DONE: begin
            state_d = S_IDLE;
            if (start) begin
               if (is_shift && (bus_in[4:0] != 5'd0)) begin
                  work_d  = y;
                  cnt_d   = bus_in[4:0];
                  sop_d   = op;
                  busy_d  = 1'b1;
                  state_d = S_BUSY;
               end else begin
                  z_lo_d  = res_lo;
                  z_hi_d  = res_hi;
                  done_d  = 1'b1;
                  state_d = S_DONE;
               end
            end
         end
         S_BUSY: begin
            // start is ignored here; Z holds until the final step lands.
            work_d = work_step;
            cnt_d  = cnt - 5'd1;
            if (cnt == 5'd1) begin
               z_lo_d  = work_step;
               z_hi_d  = '0;
               done_d  = 1'b1;
               state_d = S_DONE;
            end else begin
               busy_d = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      if (clr) begin
         state <= S_IDLE;
         y     <= '0;
         work  <= '0;
         cnt   <= '0;
         sop   <= '0;
         z_lo  <= '0;
         z_hi  <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= state_d;
         y     <= y_d;
         work  <= work_d;
         cnt   <= cnt_d;
         sop   <= sop_d;
         z_lo  <= z_lo_d;
         z_hi  <= z_hi_d;
         busy  <= busy_d;
         done  <= done_d;
      end
   end

endmodule

// File: tb/tb_alu_seq_stage.sv
// ---------------------------------------------------------------------------
// tb_alu_seq_stage
//   Scoreboard bench for alu_seq_stage. Each issued operation pushes its
//   expected Z and busy length; the entry is popped when done is seen.
// ---------------------------------------------------------------------------
module tb_alu_seq_stage;

   logic        clk = 1'b0;
   logic        clr;
   logic [31:0] bus_in;
   logic        y_in;
   logic        start;
   logic [3:0]  op;
   logic [31:0] z_lo;
   logic [31:0] z_hi;
   logic        busy;
   logic        done;

   alu_seq_stage dut (
      .clk    (clk),
      .clr    (clr),
      .bus_in (bus_in),
      .y_in   (y_in),
      .start  (start),
      .op     (op),
      .z_lo   (z_lo),
      .z_hi   (z_hi),
      .busy   (busy),
      .done   (done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] z;      // {z_hi, z_lo}
      int          nbusy;
   } exp_t;

   exp_t        sb[$];
   int          total = 0;
   int          bad   = 0;
   logic [31:0] y_model;
   logic [63:0] last_z;

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] model(input logic [3:0] o,
                                         input logic [31:0] ra,
                                         input logic [31:0] rb);
      logic [32:0] s;
      int          n;
      n = int'(rb[4:0]);
      case (o)
         4'h0: return {32'h0, ra & rb};
         4'h1: return {32'h0, ra | rb};
         4'h2: return {32'h0, ra ^ rb};
         4'h3: return {32'h0, ~rb};
         4'h4: return {32'h0, 32'h0 - rb};
         4'h5: begin
            s = {1'b0, ra} + {1'b0, rb};
            return {31'h0, s[32], s[31:0]};
         end
         4'h6: return {31'h0, (ra < rb), ra - rb};
         4'h7: return {32'h0, ra << n};
         4'h8: return {32'h0, ra >> n};
         4'h9: return {32'h0, 32'($signed(ra) >>> n)};
         4'hA: return (n == 0) ? {32'h0, ra} : {32'h0, (ra << n) | (ra >> (32 - n))};
         4'hB: return (n == 0) ? {32'h0, ra} : {32'h0, (ra >> n) | (ra << (32 - n))};
         default: return 64'h0;
      endcase
   endfunction

   task automatic load_y(input logic [31:0] v);
      y_in   = 1'b1;
      bus_in = v;
      @(negedge clk);
      y_in    = 1'b0;
      y_model = v;
   endtask

   // Drives start for one edge; returns at the negedge after the accepting edge.
   task automatic issue(input logic [3:0] o, input logic [31:0] rb,
                        input bit with_y);
      exp_t e;
      e.z     = model(o, y_model, rb);
      e.nbusy = (o >= 4'h7 && o <= 4'hB) ? int'(rb[4:0]) : 0;
      sb.push_back(e);
      start  = 1'b1;
      op     = o;
      bus_in = rb;
      y_in   = with_y;
      if (with_y) y_model = rb;
      @(negedge clk);
      start = 1'b0;
      y_in  = 1'b0;
   endtask

   // Waits (bounded) for done, counting busy cycles; optionally pokes a
   // start during the first busy cycle, which the DUT must ignore.
   task automatic wait_done(input bit poke);
      exp_t e;
      int   nb    = 0;
      int   guard = 0;
      while (!done && guard < 40) begin
         if (busy) begin
            nb++;
            check("z_hold", {z_hi, z_lo}, last_z);
         end
         if (poke && guard == 0) begin
            start  = 1'b1;
            op     = 4'h5;
            bus_in = 32'h1234_5678;
         end
         @(negedge clk);
         start = 1'b0;
         guard++;
      end
      e = sb.pop_front();
      check("done_seen", {63'h0, done}, 64'h1);
      if (done) begin
         check("z", {z_hi, z_lo}, e.z);
         check("busy_cycles", 64'(nb), 64'(e.nbusy));
         check("busy_at_done", {63'h0, busy}, 64'h0);
         last_z = e.z;
      end
   endtask

   task automatic idle_check;
      @(negedge clk);
      check("done_pulse", {63'h0, done}, 64'h0);
      check("busy_idle", {63'h0, busy}, 64'h0);
      check("z_after", {z_hi, z_lo}, last_z);
   endtask

   initial begin
      clr     = 1'b1;
      bus_in  = '0;
      y_in    = 1'b0;
      start   = 1'b0;
      op      = '0;
      y_model = '0;
      last_z  = '0;
      repeat (3) @(negedge clk);
      check("rst_z_lo", {32'h0, z_lo}, 64'h0);
      check("rst_z_hi", {32'h0, z_hi}, 64'h0);
      check("rst_busy", {63'h0, busy}, 64'h0);
      check("rst_done", {63'h0, done}, 64'h0);
      clr = 1'b0;
      @(negedge clk);

      // AND
      load_y(32'hAAAA_AAAA);
      issue(4'h0, 32'h5555_5555, 1'b0); wait_done(1'b0); idle_check();
      // ADD with carry, SUB with borrow
      load_y(32'hFFFF_FFFF);
      issue(4'h5, 32'h0000_0001, 1'b0); wait_done(1'b0); idle_check();
      load_y(32'h0000_0037);
      issue(4'h6, 32'h0000_0073, 1'b0); wait_done(1'b0); idle_check();
      // SHRA and ROR by 4
      load_y(32'h8000_0001);
      issue(4'h9, 32'h0000_0004, 1'b0); wait_done(1'b0); idle_check();
      issue(4'hB, 32'h0000_0004, 1'b0); wait_done(1'b0); idle_check();
      // SHL with count 0 (bit 5 ignored)
      load_y(32'hDEAD_BEEF);
      issue(4'h7, 32'h0000_0020, 1'b0); wait_done(1'b0); idle_check();
      // start during BUSY ignored
      load_y(32'h0000_0001);
      issue(4'h7, 32'h0000_0005, 1'b0); wait_done(1'b1); idle_check();
      // clr at cycle 2 of ROL by 10
      load_y(32'h1234_5678);
      issue(4'hA, 32'h0000_000A, 1'b0);
      @(negedge clk);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      check("clr_z_lo", {32'h0, z_lo}, 64'h0);
      check("clr_z_hi", {32'h0, z_hi}, 64'h0);
      check("clr_busy", {63'h0, busy}, 64'h0);
      check("clr_done", {63'h0, done}, 64'h0);
      void'(sb.pop_front());
      y_model = '0;
      last_z  = '0;
      // Y was cleared, so OR returns Rb
      issue(4'h1, 32'h0000_0005, 1'b0); wait_done(1'b0); idle_check();
      // illegal op
      load_y(32'hFFFF_0000);
      issue(4'h3, 32'h0F0F_0000, 1'b0); wait_done(1'b0);
      issue(4'hE, 32'h1111_1111, 1'b0); wait_done(1'b0); idle_check();
      // same-cycle y_in and start: op uses old Y, Y takes bus_in
      load_y(32'h0F0F_0F0F);
      issue(4'h5, 32'h0101_0101, 1'b1); wait_done(1'b0); idle_check();
      issue(4'h2, 32'h0000_0000, 1'b0); wait_done(1'b0); idle_check();
      // back-to-back starts from DONE
      load_y(32'h0000_0007);
      issue(4'h5, 32'h0000_0001, 1'b0); wait_done(1'b0);
      issue(4'h8, 32'h0000_0001, 1'b0); wait_done(1'b0);
      issue(4'h4, 32'h0000_0003, 1'b0); wait_done(1'b0); idle_check();
      // random mix
      for (int i = 0; i < 16; i++) begin
         load_y($urandom);
         issue(4'($urandom_range(0, 15)), $urandom, 1'b0);
         wait_done(1'b0);
         idle_check();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
